// File: rtl/nibble_add_sched_pkg.sv
// nibble_add_sched_pkg
// Shared definitions for the nibble-serial adder scheduler:
//   state_t  - FSM state encoding (IDLE = 0, ADD = 1, DONE = 2)
//   NIBBLE_W - width of one adder pass (4 bits)
package nibble_add_sched_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add_sched_nibble_adder.sv
// nibble_adder
// Combinational NIBBLE_W-bit ripple-carry adder, time-shared by the
// scheduler across all nibbles of an operation.
// Ports:
//   A, B  in  operand nibbles
//   Cin   in  carry-in
//   S     out sum nibble
//   Cout  out carry-out of the most significant bit
module nibble_adder
  import nibble_add_sched_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Cin,
  output logic [NIBBLE_W-1:0] S,
  output logic                Cout
);

  logic [NIBBLE_W:0] carry;

  assign carry[0] = Cin;

  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
    assign S[gi]         = A[gi] ^ B[gi] ^ carry[gi];
    assign carry[gi + 1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
  end

  assign Cout = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_add_sched.sv
// nibble_add_sched
// Two-requester arbiter in front of a single 4-bit adder. The winning
// requester's operands are latched and added one nibble per cycle,
// least-significant first; a one-cycle done pulse reports completion.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req0/a0/b0/cin0    requester 0 request and operands
//   req1/a1/b1/cin1    requester 1 request and operands
//   gnt                one-hot grant, held through ADD and DONE
//   busy               high while an operation is in progress
//   done               one-cycle completion pulse per requester
//   S, Cout            result and final carry, valid in the done cycle
module nibble_add_sched
  import nibble_add_sched_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         cin0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         cin1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic [1:0]   done,
  output logic [W-1:0] S,
  output logic         Cout
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t              state_reg;
  logic [W-1:0]        a_reg;
  logic [W-1:0]        b_reg;
  logic [CW-1:0]       count_reg;
  logic                carry_reg;
  logic                ptr_reg;
  logic                winner_reg;
  logic [1:0]          gnt_reg;
  logic [1:0]          done_reg;
  logic [W-1:0]        s_reg;
  logic                cout_reg;

  logic                win_next;
  logic [NIBBLE_W-1:0] a_nibs [NIBBLES];
  logic [NIBBLE_W-1:0] b_nibs [NIBBLES];
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  // Contention goes to the pointer side; otherwise whoever is requesting.
  always_comb begin
    win_next = 1'b0;
    if (req0 && req1) win_next = ptr_reg;
    else              win_next = req1;
  end

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign a_nibs[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
    assign b_nibs[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
  end

  nibble_adder u_adder (
    .A    (a_nibs[count_reg]),
    .B    (b_nibs[count_reg]),
    .Cin  (carry_reg),
    .S    (nib_sum),
    .Cout (nib_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      count_reg  <= '0;
      carry_reg  <= 1'b0;
      ptr_reg    <= 1'b0;
      winner_reg <= 1'b0;
      gnt_reg    <= '0;
      done_reg   <= '0;
      s_reg      <= '0;
      cout_reg   <= 1'b0;
    end else begin
      done_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            winner_reg <= win_next;
            gnt_reg    <= win_next ? 2'b10 : 2'b01;
            ptr_reg    <= ~win_next;
            a_reg      <= win_next ? a1 : a0;
            b_reg      <= win_next ? b1 : b0;
            carry_reg  <= win_next ? cin1 : cin0;
            count_reg  <= '0;
            state_reg  <= ADD;
          end
        end
        ADD: begin
          s_reg[count_reg*NIBBLE_W +: NIBBLE_W] <= nib_sum;
          carry_reg <= nib_cout;
          if (count_reg == LAST) state_reg <= DONE;
          else                   count_reg <= count_reg + 1'b1;
        end
        DONE: begin
          done_reg[winner_reg] <= 1'b1;
          cout_reg             <= carry_reg;
          gnt_reg              <= '0;
          state_reg            <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt  = gnt_reg;
  assign done = done_reg;
  assign busy = (state_reg != IDLE);
  assign S    = s_reg;
  assign Cout = cout_reg;

endmodule
